// File: rtl/sine_dds_pkg.sv
// Shared constants, state encoding and small helpers for the sine DDS / phase-decode blocks.
package sine_dds_pkg;

    localparam logic [7:0] RISE_BASE   = 8'd192;
    localparam logic [7:0] FALL_BASE   = 8'd64;
    localparam int         SEARCH_BITS = 7;

    typedef enum logic [1:0] {IDLE, SEARCH, ROUND, DONE} state_t;

    // Search index k maps onto the selected monotonic half-wave, wrapping at 8 bits.
    function automatic logic [7:0] phase_of(input logic fall, input logic [SEARCH_BITS-1:0] k);
        return (fall ? FALL_BASE : RISE_BASE) + {1'b0, k};
    endfunction

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sine_lut.sv
// 256-entry offset-binary sine table, round(127.5 + 127.5*sin(2*pi*addr/256)).
// Built from a 65-entry quarter wave mirrored across the four quadrants.
module sine_lut (
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [7:0] QTAB [0:64] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
        8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
        8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
        8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
        8'd255
    };

    logic [6:0] a7, qi;

    always_comb begin
        a7 = addr[6:0];
        qi = (a7 <= 7'd64) ? a7 : (7'd0 - a7);
        if (!addr[7])
            data = QTAB[qi];
        else if (a7 == 7'd0)
            data = 8'd128;  // sin(pi) rounds up, same as sin(0)
        else
            data = 8'd255 - QTAB[qi];
    end

endmodule

// File: rtl/sine_phase_decoder.sv
// Sample -> phase decoder: bit-serial binary search over one half-wave of sine_lut.
// Define SINE_DEC_ROUND_EN to add a ROUND step that picks the nearer of k-1 / k.
module sine_phase_decoder
    import sine_dds_pkg::*;
#(
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] sample,
    input  logic       falling,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] phase,
    output logic       exact
);

    state_t                 state, state_nx;
    logic [SEARCH_BITS-1:0] k, mask, probe, step;
    logic [2:0]             bitidx;
    logic [7:0]             smp, lut_addr, lut_data;
    logic                   fall, pred, final_step;
`ifdef SINE_DEC_ROUND_EN
    logic [7:0]             lut_k;
`endif

    // bitidx runs 6..0, then wraps to 7 for one extra cycle that looks up phase(k) for exact.
    assign final_step = (bitidx == 3'd7);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    sine_lut u_lut (
        .addr (lut_addr),
        .data (lut_data)
    );

    always_comb begin
        mask  = ~({SEARCH_BITS{1'b1}} << bitidx);
        step  = 7'd1 << bitidx;
        probe = final_step ? k : (k | mask);
`ifdef SINE_DEC_ROUND_EN
        lut_addr = (state == ROUND) ? phase_of(fall, k - 7'd1) : phase_of(fall, probe);
`else
        lut_addr = phase_of(fall, probe);
`endif
        pred = fall ? (lut_data <= smp) : (lut_data >= smp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SEARCH;
`ifdef SINE_DEC_ROUND_EN
            SEARCH:  if (final_step) state_nx = ROUND;
`else
            SEARCH:  if (final_step) state_nx = DONE;
`endif
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            bitidx <= 3'd6;
            smp    <= '0;
            fall   <= 1'b0;
            phase  <= '0;
            exact  <= 1'b0;
`ifdef SINE_DEC_ROUND_EN
            lut_k  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    smp    <= sample;
                    fall   <= falling;
                    k      <= '0;
                    bitidx <= 3'd6;
                end
                SEARCH: begin
                    if (!final_step) begin
                        if (!pred) k <= k | step;
                        bitidx <= bitidx - 3'd1;
                    end else begin
                        phase <= lut_addr;
                        exact <= (lut_data == smp);
`ifdef SINE_DEC_ROUND_EN
                        lut_k <= lut_data;
`endif
                    end
                end
`ifdef SINE_DEC_ROUND_EN
                // Ties keep k, so only a strictly closer k-1 wins.
                ROUND: if (k != '0 && absdiff(lut_data, smp) < absdiff(lut_k, smp)) begin
                    phase <= lut_addr;
                    exact <= (lut_data == smp);
                end
`endif
                DONE: if (out_ready && !HOLD_LAST) begin
                    phase <= '0;
                    exact <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
